// File: rtl/truth_table_scorer.sv
// Fitness scorer: sweeps every input vector through a candidate circuit, holds each
// for SETTLE_CYCLES clocks, then compares the sampled outputs with a latched target table.
module truth_table_scorer #(
  parameter  int N_IN          = 4,
  parameter  int N_OUT         = 4,
  parameter  int SETTLE_CYCLES = 4,
  localparam int NV            = 1 << N_IN,
  localparam int TW            = N_OUT * NV,
  localparam int SW            = $clog2(TW + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TW-1:0]     target,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     score,
  output logic [NV-1:0]     mismatch_mask
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tgt_q, tgt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     acc_q, acc_d;
  logic [NV-1:0]     macc_q, macc_d;
  logic              busy_d, done_d;
  logic [SW-1:0]     score_d;
  logic [NV-1:0]     mask_d;
  logic [N_OUT-1:0]  tsel, m;
  logic [SW-1:0]     pc;

  function automatic logic [SW-1:0] popcount(input logic [N_OUT-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_OUT; i++) c += SW'(v[i]);
    return c;
  endfunction

  // The candidate is fed straight from the vector index; abort zeroes the index.
  assign dut_in = vec_q;
  assign tsel   = tgt_q[int'(vec_q) * N_OUT +: N_OUT];
  assign m      = ~(dut_out ^ tsel);
  assign pc     = popcount(m);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    macc_d  = macc_q;
    busy_d  = busy;
    done_d  = 1'b0;
    score_d = score;
    mask_d  = mismatch_mask;
    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d   = target;
          vec_d   = '0;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          acc_d   = '0;
          macc_d  = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          vec_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          acc_d          = acc_q + pc;
          macc_d[vec_q]  = ~&m;
          if (vec_q != N_IN'(NV - 1)) begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = CW'(SETTLE_CYCLES - 1);
          end else begin
            score_d = acc_q + pc;
            mask_d  = macc_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tgt_q         <= '0;
      vec_q         <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      macc_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      score         <= '0;
      mismatch_mask <= '0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      vec_q         <= vec_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      macc_q        <= macc_d;
      busy          <= busy_d;
      done          <= done_d;
      score         <= score_d;
      mismatch_mask <= mask_d;
    end
  end

endmodule

// File: tb/tb_truth_table_scorer.sv
// Directed bench for truth_table_scorer: one instance at SETTLE_CYCLES=4, one at 1.
module tb_truth_table_scorer;

  localparam int TW = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, abort_a = 1'b0;
  logic [TW-1:0] target_a = '0;
  logic [3:0]    dut_in_a, dut_out_a;
  logic          busy_a, done_a;
  logic [6:0]    score_a;
  logic [15:0]   mask_a;

  logic          start_b = 1'b0, abort_b = 1'b0;
  logic [TW-1:0] target_b = '0;
  logic [3:0]    dut_in_b, dut_out_b;
  logic          busy_b, done_b;
  logic [6:0]    score_b;
  logic [15:0]   mask_b;

  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] fmodel(input logic [3:0] x);
    return {x[0] ^ x[1], x[3] & x[2], x[1] | x[3], ~x[0]};
  endfunction

  assign dut_out_a = fmodel(dut_in_a);
  assign dut_out_b = dut_in_b;

  truth_table_scorer #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(4)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a), .target(target_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
    .score(score_a), .mismatch_mask(mask_a));

  truth_table_scorer #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(1)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b), .target(target_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
    .score(score_b), .mismatch_mask(mask_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a(input string tag);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy_a), 32'd1);
  endtask

  // Counts edges after the accepting edge until done; also tracks dut_in each cycle.
  task automatic wait_done_a(input string tag, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < exp_lat + 20) begin
      step();
      lat++;
      if (lat <= exp_lat)
        chk({tag, "_dutin"}, 32'(dut_in_a), (lat / 4 > 15) ? 32'd15 : 32'(lat / 4));
      if (done_a) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_off"}, 32'(busy_a), 32'd0);
    step();
    chk({tag, "_done_pulse"}, 32'(done_a), 32'd0);
    chk({tag, "_dutin_hold"}, 32'(dut_in_a), 32'd15);
  endtask

  task automatic wait_done_b(input string tag, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < exp_lat + 20) begin
      step();
      lat++;
      if (lat <= exp_lat)
        chk({tag, "_dutin"}, 32'(dut_in_b), (lat > 15) ? 32'd15 : 32'(lat));
      if (done_b) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  logic [TW-1:0] model_tbl, ident_tbl;
  int dones;

  initial begin
    for (int v = 0; v < 16; v++) begin
      model_tbl[v*4 +: 4] = fmodel(4'(v));
      ident_tbl[v*4 +: 4] = 4'(v);
    end

    // Reset values
    #12;
    chk("rst_dutin", 32'(dut_in_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_score", 32'(score_a), 32'd0);
    chk("rst_mask", 32'(mask_a), 32'd0);
    #5 reset_n = 1'b1;
    step();

    // 1: exact match
    target_a = model_tbl;
    pulse_start_a("t1");
    wait_done_a("t1", 64);
    chk("t1_score", 32'(score_a), 32'd64);
    chk("t1_mask", 32'(mask_a), 32'h0000);

    // 2: every bit inverted
    target_a = ~model_tbl;
    pulse_start_a("t2");
    wait_done_a("t2", 64);
    chk("t2_score", 32'(score_a), 32'd0);
    chk("t2_mask", 32'(mask_a), 32'hFFFF);

    // 3: single flipped bit; target scrambled after start must not matter
    target_a = model_tbl;
    target_a[5*4+2] = ~target_a[5*4+2];
    pulse_start_a("t3");
    target_a = '0;
    wait_done_a("t3", 64);
    chk("t3_score", 32'(score_a), 32'd63);
    chk("t3_mask", 32'(mask_a), 32'h0020);

    // 4: starts while busy (incl. the completing edge) ignored; abort run keeps old result
    target_a = model_tbl;
    pulse_start_a("t4a");
    dones = 0;
    for (int k = 1; k <= 64; k++) begin
      start_a = (k == 10 || k == 40 || k == 64);
      step();
      if (done_a) begin
        dones++;
        chk("t4a_done_edge", 32'(k), 32'd64);
      end
    end
    start_a = 1'b0;
    chk("t4a_ndone", 32'(dones), 32'd1);
    chk("t4a_score", 32'(score_a), 32'd64);
    step();
    chk("t4a_late_start_ignored", 32'(busy_a), 32'd0);
    target_a = ~model_tbl;
    pulse_start_a("t4b");
    repeat (29) step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("t4b_abort_busy", 32'(busy_a), 32'd0);
    chk("t4b_abort_dutin", 32'(dut_in_a), 32'd0);
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (done_a) dones++;
    end
    chk("t4b_no_done", 32'(dones), 32'd0);
    chk("t4b_score_kept", 32'(score_a), 32'd64);
    chk("t4b_mask_kept", 32'(mask_a), 32'h0000);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("t4c_idle_abort_busy", 32'(busy_a), 32'd0);
    chk("t4c_idle_abort_score", 32'(score_a), 32'd64);

    // 5: reset mid-run, then a fresh run
    target_a = ~model_tbl;
    pulse_start_a("t5");
    repeat (19) step();
    reset_n = 1'b0;
    #2;
    chk("t5_rst_busy", 32'(busy_a), 32'd0);
    chk("t5_rst_dutin", 32'(dut_in_a), 32'd0);
    chk("t5_rst_score", 32'(score_a), 32'd0);
    chk("t5_rst_mask", 32'(mask_a), 32'd0);
    chk("t5_rst_done", 32'(done_a), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("t5_post_rst_busy", 32'(busy_a), 32'd0);
    target_a = model_tbl;
    target_a[0] = ~target_a[0];
    pulse_start_a("t5f");
    wait_done_a("t5f", 64);
    chk("t5f_score", 32'(score_a), 32'd63);
    chk("t5f_mask", 32'(mask_a), 32'h0001);

    // 6: SETTLE_CYCLES=1 with back-to-back start in the cycle done is visible
    target_b = ident_tbl;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("t6_busy_on", 32'(busy_b), 32'd1);
    wait_done_b("t6a", 16);
    chk("t6a_score", 32'(score_b), 32'd64);
    chk("t6a_mask", 32'(mask_b), 32'h0000);
    target_b = ~ident_tbl;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("t6b_b2b_busy", 32'(busy_b), 32'd1);
    wait_done_b("t6b", 16);
    chk("t6b_score", 32'(score_b), 32'd0);
    chk("t6b_mask", 32'(mask_b), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
